// File: rtl/display_cmd_decoder_if.sv
// Byte-stream and panel-status bundle between the SPI slave front-end and the
// display command decoder; the decoder sits on the slave modport.
interface display_cmd_decoder_if #(
    parameter int unsigned FB_AW = 17
);
    logic             rx_valid;
    logic [7:0]       rx_byte;
    logic             rx_dc;
    logic [7:0]       tx_byte;
    logic             fb_we;
    logic [FB_AW-1:0] fb_addr;
    logic [15:0]      fb_data;
    logic             sleep_out;
    logic             display_on;
    logic [7:0]       madctl;
    logic [7:0]       colmod;
    logic             cmd_error;

    modport master (
        output rx_valid, rx_byte, rx_dc,
        input  tx_byte, fb_we, fb_addr, fb_data,
        input  sleep_out, display_on, madctl, colmod, cmd_error
    );

    modport slave (
        input  rx_valid, rx_byte, rx_dc,
        output tx_byte, fb_we, fb_addr, fb_data,
        output sleep_out, display_on, madctl, colmod, cmd_error
    );
endinterface

// File: rtl/display_cmd_decoder.sv
// ST7789-style panel emulator: decodes D/C-tagged SPI bytes into panel state,
// framebuffer pixel writes and RDDST readback. COLMOD_RGB666_EN enables 3-byte pixels.
module display_cmd_decoder #(
    parameter int unsigned DISPLAY_X = 240,
    parameter int unsigned DISPLAY_Y = 320,
    parameter int unsigned FB_AW     = $clog2(DISPLAY_X*DISPLAY_Y)
) (
    input logic                  clk,
    input logic                  reset,
    display_cmd_decoder_if.slave bus
);
    localparam int unsigned CW = 16;
    localparam int unsigned PW = 3;

    localparam logic [7:0] OP_SWRESET = 8'h01;
    localparam logic [7:0] OP_RDDST   = 8'h09;
    localparam logic [7:0] OP_SLPOUT  = 8'h11;
    localparam logic [7:0] OP_DISPON  = 8'h29;
    localparam logic [7:0] OP_CASET   = 8'h2A;
    localparam logic [7:0] OP_PASET   = 8'h2B;
    localparam logic [7:0] OP_RAMWR   = 8'h2C;
    localparam logic [7:0] OP_MADCTL  = 8'h36;
    localparam logic [7:0] OP_COLMOD  = 8'h3A;

    localparam logic [7:0]    COLMOD_RST = 8'h66;
    localparam logic [CW-1:0] XE_RST     = CW'(DISPLAY_X - 1);
    localparam logic [CW-1:0] YE_RST     = CW'(DISPLAY_Y - 1);

    typedef enum logic [1:0] {IDLE, PARAM, RAMWR, READ} state_t;

    state_t           state_q, state_d;
    logic [7:0]       cmd_q, cmd_d;
    logic [PW-1:0]    pcnt_q, pcnt_d;
    logic [23:0]      pbuf_q, pbuf_d;
    logic [CW-1:0]    xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
    logic [CW-1:0]    col_q, col_d, row_q, row_d;
    logic [1:0]       pix_cnt_q, pix_cnt_d;
    logic [7:0]       pix_b0_q, pix_b0_d;
    logic [23:0]      stat_q, stat_d;
    logic [2:0]       rd_idx_q, rd_idx_d;
    logic             sleep_q, sleep_d;
    logic             disp_q, disp_d;
    logic [7:0]       madctl_q, madctl_d;
    logic [7:0]       colmod_q, colmod_d;
    logic [7:0]       tx_q, tx_d;
    logic             fb_we_q, fb_we_d;
    logic [FB_AW-1:0] fb_addr_q, fb_addr_d;
    logic [15:0]      fb_data_q, fb_data_d;
    logic             err_q, err_d;

    logic [PW-1:0]    param_len_c;
    logic [1:0]       pix_last_c;
    logic [CW-1:0]    param_start_c, param_end_c;
    logic             pix_in_range_c;
    logic [15:0]      pix_word_c;

`ifdef COLMOD_RGB666_EN
    logic [5:0]       pix_g_q, pix_g_d;
`endif

    // Window commands carry four parameter bytes, the rest one.
    assign param_len_c   = (cmd_q == OP_CASET || cmd_q == OP_PASET) ? PW'(4) : PW'(1);
    assign param_start_c = pbuf_q[23:8];
    assign param_end_c   = {pbuf_q[7:0], bus.rx_byte};
    assign pix_in_range_c = (32'(col_q) < DISPLAY_X) && (32'(row_q) < DISPLAY_Y);

`ifdef COLMOD_RGB666_EN
    assign pix_last_c = (colmod_q[2:0] == 3'b110) ? 2'd2 : 2'd1;
    assign pix_word_c = (pix_last_c == 2'd2) ? {pix_b0_q[7:3], pix_g_q, bus.rx_byte[7:3]}
                                             : {pix_b0_q, bus.rx_byte};
`else
    assign pix_last_c = 2'd1;
    assign pix_word_c = {pix_b0_q, bus.rx_byte};
`endif

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cmd_q     <= '0;
            pcnt_q    <= '0;
            pbuf_q    <= '0;
            xs_q      <= '0;
            xe_q      <= XE_RST;
            ys_q      <= '0;
            ye_q      <= YE_RST;
            col_q     <= '0;
            row_q     <= '0;
            pix_cnt_q <= '0;
            pix_b0_q  <= '0;
            stat_q    <= '0;
            rd_idx_q  <= '0;
            sleep_q   <= 1'b0;
            disp_q    <= 1'b0;
            madctl_q  <= '0;
            colmod_q  <= COLMOD_RST;
            tx_q      <= '0;
            fb_we_q   <= 1'b0;
            fb_addr_q <= '0;
            fb_data_q <= '0;
            err_q     <= 1'b0;
`ifdef COLMOD_RGB666_EN
            pix_g_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            pcnt_q    <= pcnt_d;
            pbuf_q    <= pbuf_d;
            xs_q      <= xs_d;
            xe_q      <= xe_d;
            ys_q      <= ys_d;
            ye_q      <= ye_d;
            col_q     <= col_d;
            row_q     <= row_d;
            pix_cnt_q <= pix_cnt_d;
            pix_b0_q  <= pix_b0_d;
            stat_q    <= stat_d;
            rd_idx_q  <= rd_idx_d;
            sleep_q   <= sleep_d;
            disp_q    <= disp_d;
            madctl_q  <= madctl_d;
            colmod_q  <= colmod_d;
            tx_q      <= tx_d;
            fb_we_q   <= fb_we_d;
            fb_addr_q <= fb_addr_d;
            fb_data_q <= fb_data_d;
            err_q     <= err_d;
`ifdef COLMOD_RGB666_EN
            pix_g_q   <= pix_g_d;
`endif
        end
    end

    // Next-state and output decode; one received byte handled per cycle.
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        pcnt_d    = pcnt_q;
        pbuf_d    = pbuf_q;
        xs_d      = xs_q;
        xe_d      = xe_q;
        ys_d      = ys_q;
        ye_d      = ye_q;
        col_d     = col_q;
        row_d     = row_q;
        pix_cnt_d = pix_cnt_q;
        pix_b0_d  = pix_b0_q;
        stat_d    = stat_q;
        rd_idx_d  = rd_idx_q;
        sleep_d   = sleep_q;
        disp_d    = disp_q;
        madctl_d  = madctl_q;
        colmod_d  = colmod_q;
        tx_d      = tx_q;
        fb_we_d   = 1'b0;
        fb_addr_d = fb_addr_q;
        fb_data_d = fb_data_q;
        err_d     = 1'b0;
`ifdef COLMOD_RGB666_EN
        pix_g_d   = pix_g_q;
`endif

        if (bus.rx_valid && !bus.rx_dc) begin
            // A command always closes whatever was in progress.
            if (state_q == PARAM && pcnt_q < param_len_c) err_d = 1'b1;
            state_d   = IDLE;
            pcnt_d    = '0;
            pix_cnt_d = '0;
            rd_idx_d  = '0;
            case (bus.rx_byte)
                OP_SWRESET: begin
                    sleep_d   = 1'b0;
                    disp_d    = 1'b0;
                    madctl_d  = '0;
                    colmod_d  = COLMOD_RST;
                    xs_d      = '0;
                    xe_d      = XE_RST;
                    ys_d      = '0;
                    ye_d      = YE_RST;
                    tx_d      = '0;
                    fb_addr_d = '0;
                    fb_data_d = '0;
                    err_d     = 1'b0;
                end
                OP_SLPOUT: sleep_d = 1'b1;
                OP_DISPON: disp_d  = 1'b1;
                OP_MADCTL, OP_COLMOD, OP_CASET, OP_PASET: begin
                    state_d = PARAM;
                    cmd_d   = bus.rx_byte;
                end
                OP_RAMWR: begin
                    state_d = RAMWR;
                    col_d   = xs_q;
                    row_d   = ys_q;
                end
                OP_RDDST: begin
                    state_d = READ;
                    tx_d    = '0;
                    stat_d  = {sleep_q, madctl_q[7:3], 2'b00,
                               1'b0, colmod_q[6:4], 4'b0000,
                               5'b00000, disp_q, 2'b00};
                end
                default: err_d = 1'b1;
            endcase
        end else if (bus.rx_valid) begin
            case (state_q)
                IDLE: err_d = 1'b1;
                PARAM: begin
                    // Bytes past the expected count are ignored.
                    if (pcnt_q < param_len_c) begin
                        pcnt_d = pcnt_q + PW'(1);
                        pbuf_d = {pbuf_q[15:0], bus.rx_byte};
                        if (pcnt_q == param_len_c - PW'(1)) begin
                            case (cmd_q)
                                OP_MADCTL: madctl_d = bus.rx_byte;
                                OP_COLMOD: colmod_d = bus.rx_byte;
                                OP_CASET: begin
                                    if (param_start_c <= param_end_c) begin
                                        xs_d = param_start_c;
                                        xe_d = param_end_c;
                                    end else begin
                                        err_d = 1'b1;
                                    end
                                end
                                OP_PASET: begin
                                    if (param_start_c <= param_end_c) begin
                                        ys_d = param_start_c;
                                        ye_d = param_end_c;
                                    end else begin
                                        err_d = 1'b1;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                RAMWR: begin
                    if (pix_cnt_q == pix_last_c) begin
                        pix_cnt_d = '0;
                        if (pix_in_range_c) begin
                            fb_we_d   = 1'b1;
                            fb_addr_d = FB_AW'(32'(row_q) * DISPLAY_X + 32'(col_q));
                            fb_data_d = pix_word_c;
                        end
                        // Counters advance even for off-panel pixels.
                        if (col_q == xe_q) begin
                            col_d = xs_q;
                            row_d = (row_q == ye_q) ? ys_q : row_q + CW'(1);
                        end else begin
                            col_d = col_q + CW'(1);
                        end
                    end else begin
                        pix_cnt_d = pix_cnt_q + 2'd1;
                        if (pix_cnt_q == 2'd0) pix_b0_d = bus.rx_byte;
`ifdef COLMOD_RGB666_EN
                        else pix_g_d = bus.rx_byte[7:2];
`endif
                    end
                end
                READ: begin
                    rd_idx_d = rd_idx_q + 3'd1;
                    case (rd_idx_q)
                        3'd0:    tx_d = stat_q[23:16];
                        3'd1:    tx_d = stat_q[15:8];
                        3'd2:    tx_d = stat_q[7:0];
                        default: tx_d = '0;
                    endcase
                    if (rd_idx_q == 3'd4) state_d = IDLE;
                end
                default: ;
            endcase
        end
    end

    assign bus.tx_byte    = tx_q;
    assign bus.fb_we      = fb_we_q;
    assign bus.fb_addr    = fb_addr_q;
    assign bus.fb_data    = fb_data_q;
    assign bus.sleep_out  = sleep_q;
    assign bus.display_on = disp_q;
    assign bus.madctl     = madctl_q;
    assign bus.colmod     = colmod_q;
    assign bus.cmd_error  = err_q;
endmodule

// File: doc/display_cmd_decoder.md
Name: display_cmd_decoder

Overview:
Panel-side responder for the 4-wire SPI display protocol. Consumes received bytes tagged with the D/C line from an SPI slave front-end and decodes the ST7789-style command set. Maintains the panel configuration and address window, and streams RGB565 pixels into a framebuffer write port. Serves as the display model and panel emulator opposite the display controller, and returns RDDST status bytes for full-duplex readback.

Parameters:
DISPLAY_X, 240, panel width in pixels.
DISPLAY_Y, 320, panel height in pixels.
FB_AW, $clog2(DISPLAY_X*DISPLAY_Y), framebuffer address width (derived; do not override).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
rx_valid  in  1  one-cycle strobe: rx_byte/rx_dc valid
rx_byte  in  8  received byte
rx_dc  in  1  0 = command, 1 = data/parameter
tx_byte  out  8  byte the slave shifts out on the next transfer
fb_we  out  1  one-cycle framebuffer write strobe
fb_addr  out  FB_AW  pixel address, row*DISPLAY_X + col
fb_data  out  16  RGB565 pixel
sleep_out  out  1  set by SLPOUT
display_on  out  1  set by DISPON
madctl  out  8  MADCTL register
colmod  out  8  COLMOD register
cmd_error  out  1  one-cycle pulse on a protocol error

Behaviour:
- Reset and SWRESET (0x01) set: sleep_out=0, display_on=0, madctl=0x00, colmod=0x66, window xs=0, xe=DISPLAY_X-1, ys=0, ye=DISPLAY_Y-1, tx_byte=0x00, fb_we=0, fb_addr=0, fb_data=0, cmd_error=0, state IDLE. Asynchronous reset aborts any operation in progress. SWRESET takes effect the cycle after its rx_valid.
- States: IDLE, PARAM, RAMWR, READ. Nothing changes when rx_valid=0.
- A command byte (rx_dc=0) is accepted in any state and terminates the current state:
  - Truncated PARAM: cmd_error pulse, target register unchanged.
  - Half-received pixel in RAMWR: discarded, no error.
  - READ: aborted, no error.
- Commands:
  - 0x11 SLPOUT: sleep_out<=1.
  - 0x29 DISPON: display_on<=1.
  - 0x36 MADCTL: PARAM, 1 byte.
  - 0x3A COLMOD: PARAM, 1 byte.
  - 0x2A CASET / 0x2B PASET: PARAM, 4 bytes {SH,SL,EH,EL}, 16-bit big-endian. Committed after the 4th byte only if start<=end; otherwise cmd_error pulse and the old window is kept. Extra data bytes are ignored.
  - 0x2C RAMWR: col<=xs, row<=ys, state RAMWR.
  - 0x09 RDDST: enters READ (see readback below).
  - Any other opcode: cmd_error pulse, state IDLE.
- A data byte received in IDLE is dropped with a cmd_error pulse.
- RAMWR pixel path:
  - Bytes pair MSB first. fb_we pulses for exactly one cycle, on the cycle after the second byte's rx_valid, with fb_data={b0,b1} and fb_addr=row*DISPLAY_X+col.
  - After each pixel, col increments. At col==xe, col wraps to xs and row increments. At row==ye with col==xe, row wraps to ys (window wrap-around).
  - A pixel with col>=DISPLAY_X or row>=DISPLAY_Y is not written (no fb_we), but the counters still advance.
- RDDST readback:
  - On the RDDST command, the 32-bit status is snapshotted:
    - B1={sleep_out, madctl[7:3], 2'b00}
    - B2={1'b0, colmod[6:4], 4'b0}
    - B3={5'b0, display_on, 2'b00}
    - B4=8'h00
  - tx_byte<=0x00 (dummy). Each subsequent rx_valid with rx_dc=1 advances tx_byte to B1, B2, B3, B4, then 0x00.
  - After the 5th data byte, state returns to IDLE.
  - Write-side status changes during READ do not alter the snapshot.
- Simultaneous events: at most one byte is handled per cycle. fb_we from the previous pixel may coincide with the acceptance of the next byte.

Optional Feature:
Macro COLMOD_RGB666_EN.
- Defined: while colmod[2:0]==3'b110, RAMWR takes 3 bytes per pixel (R,G,B, upper 6 bits each). fb_data={R[7:3],G[7:2],B[7:3]}, and fb_we pulses the cycle after the third byte. Any other colmod uses 2-byte RGB565.
- Undefined: every colmod value uses 2-byte RGB565 pixels. colmod is stored and reported in status only.

Test Plan:
1. DISPLAY_X=3, DISPLAY_Y=4. Send SLPOUT, MADCTL+0x00, COLMOD+0x55, DISPON, then RDDST + 5 data bytes -> tx_byte sequence 0x00,0x80,0x50,0x04,0x00; no cmd_error.
2. CASET 00 00 00 02, PASET 00 00 00 03, RAMWR + 24 bytes alternating F8 00 / 07 E0 / 00 1F -> 12 fb_we pulses at addresses 0..11 with data F800, 07E0, 001F repeating; a 13th pixel writes address 0 again.
3. CASET 00 01 00 01, PASET 00 02 00 03, RAMWR + 3 pixels -> writes at addresses 7, 10, 7.
4. CASET 00 05 00 02 -> cmd_error pulse, window unchanged. Send CASET with 2 data bytes, then DISPON -> cmd_error pulse, display_on=1.
5. Assert reset mid-RAMWR after one byte -> all outputs return to reset values immediately. A following RAMWR + 2 bytes writes address 0.
6. With COLMOD_RGB666_EN defined, COLMOD 0x66, RAMWR FC 00 00 -> fb_data=F800 after the 3rd byte. Without the macro, the same bytes give fb_data=FC00 after the 2nd byte.
